// File: rtl/alu_pkg.sv
// Shared types and tables for the RV32I ALU built-in self-test driver.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam int unsigned NUM_OPS = 10;

  localparam alu_op_e OP_ORDER [NUM_OPS] = '{
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  };

  localparam logic [31:0] CORNER [8] = '{
    32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
    32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_001F
  };

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // Right-shifting Galois form: the bit shifted out decides whether the taps are folded in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU used to predict the result of every BIST vector.
module alu_golden_model
  import alu_pkg::*;
(
  input  logic    [31:0] i_a,
  input  logic    [31:0] i_b,
  input  alu_op_e        i_op,
  output logic    [31:0] o_result
);

  logic [4:0] shamt;

  always_comb begin
    shamt    = i_b[4:0];
    o_result = 32'h0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << shamt;
      ALU_SLT:  o_result = {31'h0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result = {31'h0, i_a < i_b};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> shamt);
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_bist_driver.sv
// BIST initiator: sweeps corner and LFSR vectors through the ALU for every opcode,
// compares against the golden model and records pass/fail plus the first failing vector.
module alu_bist_driver
  import alu_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned DUT_LATENCY = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_err_count,
  output logic [3:0]  o_fail_op,
  output logic [31:0] o_fail_a,
  output logic [31:0] o_fail_b
);

  localparam int          VW       = $clog2(NUM_VECTORS) + 1;
  localparam int          LW       = $clog2(DUT_LATENCY + 1) + 1;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  bist_state_e    state_q, state_d;
  logic [3:0]     op_idx_q, op_idx_d;
  logic [VW-1:0]  vec_q, vec_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [31:0]    lfsr_q, lfsr_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  alu_op_e        alu_op_q, alu_op_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [15:0]    err_q, err_d;
  logic           fail_seen_q, fail_seen_d;
  logic [3:0]     fail_op_q, fail_op_d;
  logic [31:0]    fail_a_q, fail_a_d;
  logic [31:0]    fail_b_q, fail_b_d;

  logic [31:0]    golden;
  logic [31:0]    lfsr_adv;
  logic [VW-1:0]  next_vec;
  logic [3:0]     next_op;
  logic [2:0]     b_idx;
  logic           mismatch;

  alu_golden_model u_golden (
    .i_a      (op_a_q),
    .i_b      (op_b_q),
    .i_op     (alu_op_q),
    .o_result (golden)
  );

  always_comb begin
    state_d     = state_q;
    op_idx_d    = op_idx_q;
    vec_d       = vec_q;
    lat_d       = lat_q;
    lfsr_d      = lfsr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    alu_op_d    = alu_op_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_seen_d = fail_seen_q;
    fail_op_d   = fail_op_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    lfsr_adv    = lfsr_step(lfsr_q);
    next_vec    = '0;
    next_op     = 4'h0;
    b_idx       = 3'h0;
    mismatch    = (i_alu_data != golden);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_DRIVE;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = 16'h0;
          fail_seen_d = 1'b0;
          fail_op_d   = 4'h0;
          fail_a_d    = 32'h0;
          fail_b_d    = 32'h0;
          lfsr_d      = SEED_EFF;
          op_idx_d    = 4'h0;
          vec_d       = '0;
          lat_d       = '0;
          op_a_d      = CORNER[0];
          op_b_d      = CORNER[3];
          alu_op_d    = OP_ORDER[0];
        end
      end

      // Operands stay put for 1+DUT_LATENCY cycles so a pipelined ALU has settled by CHECK.
      ST_DRIVE: begin
        if (lat_q == LW'(DUT_LATENCY)) begin
          state_d = ST_CHECK;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (!fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_op_d   = alu_op_q;
            fail_a_d    = op_a_q;
            fail_b_d    = op_b_q;
          end
        end
        if (op_idx_q == 4'(NUM_OPS - 1) && vec_q == VW'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          if (vec_q == VW'(NUM_VECTORS - 1)) begin
            next_vec = '0;
            next_op  = op_idx_q + 4'd1;
          end else begin
            next_vec = vec_q + 1'b1;
            next_op  = op_idx_q;
          end
          if (next_vec < VW'(8)) begin
            b_idx  = next_vec[2:0] + 3'd3;
            op_a_d = CORNER[next_vec[2:0]];
            op_b_d = CORNER[b_idx];
          end else begin
            lfsr_d = lfsr_adv;
            op_a_d = lfsr_adv;
            op_b_d = {lfsr_adv[15:0], lfsr_adv[31:16]} ^ 32'h5A5A_5A5A;
          end
          vec_d    = next_vec;
          op_idx_d = next_op;
          alu_op_d = OP_ORDER[next_op];
          state_d  = ST_DRIVE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 16'h0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      op_idx_q    <= 4'h0;
      vec_q       <= '0;
      lat_q       <= '0;
      lfsr_q      <= SEED_EFF;
      op_a_q      <= 32'h0;
      op_b_q      <= 32'h0;
      alu_op_q    <= ALU_ADD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 16'h0;
      fail_seen_q <= 1'b0;
      fail_op_q   <= 4'h0;
      fail_a_q    <= 32'h0;
      fail_b_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_idx_q    <= op_idx_d;
      vec_q       <= vec_d;
      lat_q       <= lat_d;
      lfsr_q      <= lfsr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_op_q    <= alu_op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_seen_q <= fail_seen_d;
      fail_op_q   <= fail_op_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
    end
  end

  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_alu_op    = alu_op_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_err_count = err_q;
  assign o_fail_op   = fail_op_q;
  assign o_fail_a    = fail_a_q;
  assign o_fail_b    = fail_b_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Directed bench for alu_bist_driver: a combinational ALU with selectable faults
// drives one instance, a correct two-stage registered ALU drives a DUT_LATENCY=2 instance.
module tb_alu_bist_driver;

   localparam logic [3:0] TB_OPS [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
   localparam logic [31:0] TB_CORNER [8] = '{
      32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000,
      32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_001F
   };

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   int   faultMode = 0;

   logic [31:0] a_op_a, a_op_b, a_data, a_fail_a, a_fail_b;
   logic [3:0]  a_alu_op, a_fail_op;
   logic        a_busy, a_done, a_pass;
   logic [15:0] a_err;

   logic [31:0] b_op_a, b_op_b, b_data, b_fail_a, b_fail_b, b_s1, b_s2;
   logic [3:0]  b_alu_op, b_fail_op;
   logic        b_busy, b_done, b_pass;
   logic [15:0] b_err;

   int checks = 0;
   int passed = 0;
   int fails = 0;
   int aDoneCount = 0;

   // Free-running 100 MHz-style clock shared by both instances
   always #5 clk = ~clk;

   // Reference ALU; fault 1 makes SLTU compare signed, fault 2 makes SRA shift logically
   function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input int fault);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         4'h0: return a + b;
         4'h8: return a - b;
         4'h1: return a << sh;
         4'h2: return {31'h0, $signed(a) < $signed(b)};
         4'h3: return (fault == 1) ? {31'h0, $signed(a) < $signed(b)} : {31'h0, a < b};
         4'h4: return a ^ b;
         4'h5: return a >> sh;
         4'hD: return (fault == 2) ? (a >> sh) : $unsigned($signed(a) >>> sh);
         4'h6: return a | b;
         4'h7: return a & b;
         default: return 32'h0;
      endcase
   endfunction

   // Walks the full vector sequence and counts where a faulty ALU disagrees with a correct one
   function automatic int expectedErrors(input int fault);
      logic [31:0] lfsr, a, b;
      int n;
      n = 0;
      lfsr = 32'hACE1_2024;
      for (int o = 0; o < 10; o++) begin
         for (int v = 0; v < 16; v++) begin
            if (v < 8) begin
               a = TB_CORNER[v];
               b = TB_CORNER[(v + 3) % 8];
            end else begin
               lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
               a = lfsr;
               b = {lfsr[15:0], lfsr[31:16]} ^ 32'h5A5A_5A5A;
            end
            if (refAlu(a, b, TB_OPS[o], fault) !== refAlu(a, b, TB_OPS[o], 0)) n++;
         end
      end
      return n;
   endfunction

   assign a_data = refAlu(a_op_a, a_op_b, a_alu_op, faultMode);

   // Two register stages model a pipelined ALU behind the latency-2 instance
   always @(posedge clk) begin
      b_s1 <= refAlu(b_op_a, b_op_b, b_alu_op, 0);
      b_s2 <= b_s1;
   end
   assign b_data = b_s2;

   // Counts every done pulse so an aborted run can be shown to produce none
   always @(negedge clk) begin
      if (a_done) aDoneCount <= aDoneCount + 1;
   end

   alu_bist_driver #(.NUM_VECTORS(16), .DUT_LATENCY(0), .SEED(32'hACE1_2024)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_op_a(a_op_a), .o_op_b(a_op_b), .o_alu_op(a_alu_op), .i_alu_data(a_data),
      .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_err_count(a_err),
      .o_fail_op(a_fail_op), .o_fail_a(a_fail_a), .o_fail_b(a_fail_b)
   );

   alu_bist_driver #(.NUM_VECTORS(16), .DUT_LATENCY(2), .SEED(32'hACE1_2024)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_op_a(b_op_a), .o_op_b(b_op_b), .o_alu_op(b_alu_op), .i_alu_data(b_data),
      .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_err_count(b_err),
      .o_fail_op(b_fail_op), .o_fail_a(b_fail_a), .o_fail_b(b_fail_b)
   );

   // One comparison: counts it, and reports observed/expected on a miss
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Launches a run on both instances and times their done pulses relative to the start edge
   task automatic applyStimulus(input int pulseAt, output int aCycles, output int bCycles,
                                output int aDoneWidth, output logic busyAfterStart);
      aCycles = 0;
      bCycles = 0;
      aDoneWidth = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busyAfterStart = a_busy;
      for (int c = 1; c <= 2000 && (aCycles == 0 || bCycles == 0); c++) begin
         @(posedge clk);
         #1;
         if (a_done) aDoneWidth++;
         if (a_done && aCycles == 0) aCycles = c;
         if (b_done && bCycles == 0) bCycles = c;
         start = (c == pulseAt);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      if (a_done) aDoneWidth++;
   endtask

   initial begin
      int ca, cb, wa, doneBefore, expSltu, expSra;
      logic busy0;

      expSltu = expectedErrors(1);
      expSra  = expectedErrors(2);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy",    32'(a_busy),    32'h0);
      checkOutput("reset_done",    32'(a_done),    32'h0);
      checkOutput("reset_pass",    32'(a_pass),    32'h0);
      checkOutput("reset_err",     32'(a_err),     32'h0);
      checkOutput("reset_op_a",    a_op_a,         32'h0);
      checkOutput("reset_alu_op",  32'(a_alu_op),  32'h0);
      checkOutput("reset_fail_b",  a_fail_b,       32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] clean run, latency 0 and 2");
      applyStimulus(0, ca, cb, wa, busy0);
      checkOutput("s1_busy_after_start", 32'(busy0), 32'h1);
      checkOutput("s1_run_length",       32'(ca),    32'd321);
      checkOutput("s1_done_width",       32'(wa),    32'd1);
      checkOutput("s1_pass",             32'(a_pass), 32'h1);
      checkOutput("s1_err",              32'(a_err),  32'h0);
      checkOutput("s1_busy_after_done",  32'(a_busy), 32'h0);
      checkOutput("s5_run_length",       32'(cb),     32'd641);
      checkOutput("s5_pass",             32'(b_pass), 32'h1);
      checkOutput("s5_err",              32'(b_err),  32'h0);

      $display("[TB] SLTU behaving as SLT");
      faultMode = 1;
      applyStimulus(0, ca, cb, wa, busy0);
      checkOutput("s2_run_length", 32'(ca),        32'd321);
      checkOutput("s2_pass",       32'(a_pass),    32'h0);
      checkOutput("s2_fail_op",    32'(a_fail_op), 32'h3);
      checkOutput("s2_fail_a",     a_fail_a,       32'h0);
      checkOutput("s2_fail_b",     a_fail_b,       32'h8000_0000);
      checkOutput("s2_err",        32'(a_err),     32'(expSltu));

      $display("[TB] SRA behaving as SRL");
      faultMode = 2;
      applyStimulus(0, ca, cb, wa, busy0);
      checkOutput("s3_pass",    32'(a_pass),    32'h0);
      checkOutput("s3_fail_op", 32'(a_fail_op), 32'hD);
      checkOutput("s3_fail_a",  a_fail_a,       32'h8000_0000);
      checkOutput("s3_fail_b",  a_fail_b,       32'h5555_5555);
      checkOutput("s3_err",     32'(a_err),     32'(expSra));

      $display("[TB] reset during SUB vectors");
      faultMode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("s4_in_sub", 32'(a_alu_op), 32'h8);
      #2;
      doneBefore = aDoneCount;
      rst_n = 1'b0;
      #1;
      checkOutput("s4_rst_busy",   32'(a_busy),   32'h0);
      checkOutput("s4_rst_op_a",   a_op_a,        32'h0);
      checkOutput("s4_rst_op_b",   a_op_b,        32'h0);
      checkOutput("s4_rst_alu_op", 32'(a_alu_op), 32'h0);
      checkOutput("s4_rst_fail_a", a_fail_a,      32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (700) @(negedge clk);
      checkOutput("s4_no_done", 32'(aDoneCount), 32'(doneBefore));
      applyStimulus(0, ca, cb, wa, busy0);
      checkOutput("s4_rerun_length", 32'(ca),     32'd321);
      checkOutput("s4_rerun_pass",   32'(a_pass), 32'h1);
      checkOutput("s4_rerun_err",    32'(a_err),  32'h0);

      $display("[TB] start while busy, back-to-back runs");
      faultMode = 1;
      applyStimulus(50, ca, cb, wa, busy0);
      checkOutput("s6_run_length", 32'(ca),        32'd321);
      checkOutput("s6_err_run1",   32'(a_err),     32'(expSltu));
      checkOutput("s6_fail_b_r1",  a_fail_b,       32'h8000_0000);
      applyStimulus(0, ca, cb, wa, busy0);
      checkOutput("s6_err_run2",   32'(a_err),     32'(expSltu));
      checkOutput("s6_fail_op_r2", 32'(a_fail_op), 32'h3);
      checkOutput("s6_fail_a_r2",  a_fail_a,       32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
